// File: rtl/cmd_bus_seq.sv
// Per-bus command sequencer: captures one command from an arbiter lane and drives it
// on a node bus with a valid/ack/nak handshake, credit limit, turnaround gap and nak retry.
module cmd_bus_seq #(
   parameter int unsigned CMD_W     = 64,
   parameter int unsigned VLD_BIT   = 63,
   parameter int unsigned CREDITS   = 4,
   parameter int unsigned TURN      = 1,
   parameter int unsigned BACKOFF   = 4,
   parameter int unsigned MAX_RETRY = 3,
   localparam int unsigned CRW      = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CMD_W-1:0] cmd_in,
   output logic             bus_rdy,
   output logic             bus_val,
   output logic [CMD_W-1:0] bus_cmd,
   input  logic             bus_ack,
   input  logic             bus_nak,
   input  logic             cr_ret,
   output logic [CRW-1:0]   credits,
   output logic             busy,
   output logic             retry_err,
   output logic             cr_ovf_err,
   output logic [15:0]      issued_cnt
);

   localparam int unsigned TMR_W = 4;
   localparam int unsigned RTW   = 3;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SEND    = 2'd1;
   localparam logic [1:0] S_BACKOFF = 2'd2;
   localparam logic [1:0] S_GAP     = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [RTW-1:0]   retry_q, retry_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CRW-1:0]   credits_q, credits_d;
   logic [15:0]      issued_q, issued_d;
   logic             retry_err_q, retry_err_d;
   logic             ovf_q, ovf_d;
   logic             bus_rdy_q, bus_rdy_d;
   logic             bus_val_q, bus_val_d;
   logic [CMD_W-1:0] bus_cmd_q, bus_cmd_d;
   logic             busy_q, busy_d;
   logic             ack_c;

   // Handshake inputs only count while a command is actually on the bus.
   assign ack_c = (state_q == S_SEND) & bus_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         retry_q     <= '0;
         tmr_q       <= '0;
         credits_q   <= CRW'(CREDITS);
         issued_q    <= '0;
         retry_err_q <= 1'b0;
         ovf_q       <= 1'b0;
         bus_rdy_q   <= (CREDITS != 0);
         bus_val_q   <= 1'b0;
         bus_cmd_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         retry_q     <= retry_d;
         tmr_q       <= tmr_d;
         credits_q   <= credits_d;
         issued_q    <= issued_d;
         retry_err_q <= retry_err_d;
         ovf_q       <= ovf_d;
         bus_rdy_q   <= bus_rdy_d;
         bus_val_q   <= bus_val_d;
         bus_cmd_q   <= bus_cmd_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      retry_d     = retry_q;
      tmr_d       = tmr_q;
      credits_d   = credits_q;
      issued_d    = issued_q;
      retry_err_d = 1'b0;
      ovf_d       = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (bus_rdy_q && cmd_in[VLD_BIT]) begin
               cmd_d   = cmd_in;
               retry_d = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (bus_ack) begin
               issued_d = issued_q + 16'd1;
               if (TURN == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  tmr_d   = TMR_W'(TURN);
               end
            end else if (bus_nak) begin
               if (retry_q == RTW'(MAX_RETRY)) begin
                  retry_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  retry_d = retry_q + RTW'(1);
                  state_d = S_BACKOFF;
                  tmr_d   = TMR_W'(BACKOFF);
               end
            end
         end
         S_BACKOFF: begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q == TMR_W'(1)) state_d = S_SEND;
         end
         default: begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q == TMR_W'(1)) state_d = S_IDLE;
         end
      endcase

      // Ack consumes a credit, cr_ret returns one; together they cancel.
      case ({ack_c, cr_ret})
         2'b10: begin
            if (credits_q != '0) credits_d = credits_q - CRW'(1);
         end
         2'b01: begin
            if (credits_q == CRW'(CREDITS)) ovf_d = 1'b1;
            else credits_d = credits_q + CRW'(1);
         end
         default: ;
      endcase
   end

   // Outputs are registered from next-state so they line up with state_q.
   always_comb begin
      bus_rdy_d = (state_d == S_IDLE) && (credits_d != '0);
      bus_val_d = (state_d == S_SEND);
      bus_cmd_d = bus_val_d ? cmd_d : '0;
      busy_d    = (state_d != S_IDLE);
   end

   assign bus_rdy    = bus_rdy_q;
   assign bus_val    = bus_val_q;
   assign bus_cmd    = bus_cmd_q;
   assign credits    = credits_q;
   assign busy       = busy_q;
   assign retry_err  = retry_err_q;
   assign cr_ovf_err = ovf_q;
   assign issued_cnt = issued_q;

endmodule

// File: tb/tb_cmd_bus_seq.sv
// Directed bench for cmd_bus_seq: captured commands go into a scoreboard queue and are
// popped when the bus presents them for ack; control outputs are checked against constants.
module tb_cmd_bus_seq;

   localparam int unsigned CMD_W = 64;
   localparam int unsigned CRW   = 3;

   logic             clk;
   logic             rst;
   logic [CMD_W-1:0] cmd_in;
   logic             bus_rdy;
   logic             bus_val;
   logic [CMD_W-1:0] bus_cmd;
   logic             bus_ack;
   logic             bus_nak;
   logic             cr_ret;
   logic [CRW-1:0]   credits;
   logic             busy;
   logic             retry_err;
   logic             cr_ovf_err;
   logic [15:0]      issued_cnt;

   int               n_cmp;
   int               n_err;
   int unsigned      exp_iss;
   logic [63:0]      exp_q[$];

   cmd_bus_seq #(
      .CMD_W(64), .VLD_BIT(63), .CREDITS(4), .TURN(1), .BACKOFF(4), .MAX_RETRY(3)
   ) dut (
      .clk(clk), .rst(rst), .cmd_in(cmd_in), .bus_rdy(bus_rdy), .bus_val(bus_val),
      .bus_cmd(bus_cmd), .bus_ack(bus_ack), .bus_nak(bus_nak), .cr_ret(cr_ret),
      .credits(credits), .busy(busy), .retry_err(retry_err), .cr_ovf_err(cr_ovf_err),
      .issued_cnt(issued_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Capture c, ack it at the earliest cycle, then wait out the gap.
   task automatic send_ack(input logic [63:0] c);
      chk("rdy_before_capture", 64'(bus_rdy), 64'd1);
      cmd_in = c;
      exp_q.push_back(c);
      tick();
      cmd_in = '0;
      chk("val_on_send", 64'(bus_val), 64'd1);
      chk("cmd_on_send", bus_cmd, exp_q.pop_front());
      bus_ack = 1'b1;
      exp_iss++;
      tick();
      bus_ack = 1'b0;
      chk("issued_after_ack", 64'(issued_cnt), 64'(exp_iss));
      tick();
      tick();
   endtask

   // Nak the command on the bus, expect BACKOFF idle cycles, then the same command again.
   task automatic nak_wait();
      bus_nak = 1'b1;
      tick();
      bus_nak = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("val_low_backoff", 64'(bus_val), 64'd0);
         chk("retry_err_backoff", 64'(retry_err), 64'd0);
         tick();
      end
      chk("val_resend", 64'(bus_val), 64'd1);
      chk("cmd_resend", bus_cmd, exp_q[0]);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      exp_iss = 0;
      rst     = 1'b1;
      cmd_in  = '0;
      bus_ack = 1'b0;
      bus_nak = 1'b0;
      cr_ret  = 1'b0;
      tick();
      tick();

      chk("rst_bus_val", 64'(bus_val), 64'd0);
      chk("rst_bus_cmd", bus_cmd, 64'd0);
      chk("rst_credits", 64'(credits), 64'd4);
      chk("rst_issued", 64'(issued_cnt), 64'd0);
      chk("rst_retry_err", 64'(retry_err), 64'd0);
      chk("rst_ovf", 64'(cr_ovf_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick();
      chk("rdy_after_rst", 64'(bus_rdy), 64'd1);

      // Single command, ack one cycle after it appears
      cmd_in = 64'h8000_0000_0000_00A5;
      exp_q.push_back(64'h8000_0000_0000_00A5);
      tick();
      cmd_in = '0;
      chk("t1_rdy_c1", 64'(bus_rdy), 64'd0);
      chk("t1_val_c1", 64'(bus_val), 64'd1);
      chk("t1_cmd_c1", bus_cmd, exp_q[0]);
      tick();
      chk("t1_val_c2", 64'(bus_val), 64'd1);
      chk("t1_cmd_c2", bus_cmd, exp_q.pop_front());
      bus_ack = 1'b1;
      exp_iss++;
      tick();
      bus_ack = 1'b0;
      chk("t1_credits_c3", 64'(credits), 64'd3);
      chk("t1_issued_c3", 64'(issued_cnt), 64'(exp_iss));
      chk("t1_rdy_c3", 64'(bus_rdy), 64'd0);
      chk("t1_val_c3", 64'(bus_val), 64'd0);
      chk("t1_cmd_c3", bus_cmd, 64'd0);
      tick();
      chk("t1_rdy_c4", 64'(bus_rdy), 64'd1);

      // Credit exhaustion
      for (int i = 0; i < 3; i++) send_ack(64'h8000_0000_0000_0100 + 64'(i));
      chk("ex_credits_zero", 64'(credits), 64'd0);
      chk("ex_rdy_low", 64'(bus_rdy), 64'd0);
      cmd_in = 64'h8000_0000_0000_0BEE;
      tick();
      chk("ex_no_capture_val", 64'(bus_val), 64'd0);
      chk("ex_no_capture_busy", 64'(busy), 64'd0);
      chk("ex_rdy_still_low", 64'(bus_rdy), 64'd0);
      cr_ret = 1'b1;
      tick();
      cr_ret = 1'b0;
      chk("ex_credits_one", 64'(credits), 64'd1);
      chk("ex_rdy_back", 64'(bus_rdy), 64'd1);
      exp_q.push_back(cmd_in);
      tick();
      cmd_in = '0;
      chk("ex_val_captured", 64'(bus_val), 64'd1);
      chk("ex_cmd_captured", bus_cmd, exp_q.pop_front());
      bus_ack = 1'b1;
      exp_iss++;
      tick();
      bus_ack = 1'b0;
      chk("ex_credits_zero2", 64'(credits), 64'd0);
      cr_ret = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      cr_ret = 1'b0;
      chk("ex_credits_refill", 64'(credits), 64'd4);
      chk("ex_no_ovf", 64'(cr_ovf_err), 64'd0);
      chk("ex_issued", 64'(issued_cnt), 64'(exp_iss));

      // Retry: two naks then ack
      cmd_in = 64'h8000_0000_0000_C0DE;
      exp_q.push_back(cmd_in);
      tick();
      cmd_in = '0;
      chk("rt_cmd_first", bus_cmd, exp_q[0]);
      nak_wait();
      nak_wait();
      chk("rt_cmd_final", bus_cmd, exp_q.pop_front());
      bus_ack = 1'b1;
      exp_iss++;
      tick();
      bus_ack = 1'b0;
      chk("rt_issued", 64'(issued_cnt), 64'(exp_iss));
      chk("rt_retry_err", 64'(retry_err), 64'd0);
      chk("rt_credits", 64'(credits), 64'd3);
      cr_ret = 1'b1;
      tick();
      cr_ret = 1'b0;
      chk("rt_credits_back", 64'(credits), 64'd4);
      chk("rt_rdy", 64'(bus_rdy), 64'd1);

      // Drop after MAX_RETRY+1 naks
      cmd_in = 64'h8000_0000_0000_0D0D;
      exp_q.push_back(cmd_in);
      tick();
      cmd_in = '0;
      nak_wait();
      nak_wait();
      nak_wait();
      bus_nak = 1'b1;
      tick();
      bus_nak = 1'b0;
      void'(exp_q.pop_front());
      chk("dr_retry_err_pulse", 64'(retry_err), 64'd1);
      chk("dr_val", 64'(bus_val), 64'd0);
      chk("dr_busy", 64'(busy), 64'd0);
      chk("dr_rdy", 64'(bus_rdy), 64'd1);
      chk("dr_credits", 64'(credits), 64'd4);
      chk("dr_issued", 64'(issued_cnt), 64'(exp_iss));
      tick();
      chk("dr_retry_err_clear", 64'(retry_err), 64'd0);

      // Ack and nak together count as ack
      cmd_in = 64'h8000_0000_0000_00E1;
      exp_q.push_back(cmd_in);
      tick();
      cmd_in = '0;
      chk("sim_cmd", bus_cmd, exp_q.pop_front());
      bus_ack = 1'b1;
      bus_nak = 1'b1;
      exp_iss++;
      tick();
      bus_ack = 1'b0;
      bus_nak = 1'b0;
      chk("sim_issued", 64'(issued_cnt), 64'(exp_iss));
      chk("sim_credits", 64'(credits), 64'd3);
      chk("sim_busy_gap", 64'(busy), 64'd1);
      chk("sim_val", 64'(bus_val), 64'd0);
      chk("sim_retry_err", 64'(retry_err), 64'd0);
      tick();

      // Ack and cr_ret together at credits=3
      cmd_in = 64'h8000_0000_0000_00F2;
      exp_q.push_back(cmd_in);
      tick();
      cmd_in = '0;
      chk("acr_cmd", bus_cmd, exp_q.pop_front());
      bus_ack = 1'b1;
      cr_ret  = 1'b1;
      exp_iss++;
      tick();
      bus_ack = 1'b0;
      cr_ret  = 1'b0;
      chk("acr_credits", 64'(credits), 64'd3);
      chk("acr_issued", 64'(issued_cnt), 64'(exp_iss));
      tick();
      cr_ret = 1'b1;
      tick();
      cr_ret = 1'b0;
      chk("acr_credits_full", 64'(credits), 64'd4);
      chk("acr_no_ovf", 64'(cr_ovf_err), 64'd0);
      cr_ret = 1'b1;
      tick();
      cr_ret = 1'b0;
      chk("ovf_set", 64'(cr_ovf_err), 64'd1);
      chk("ovf_credits_sat", 64'(credits), 64'd4);
      tick();
      chk("ovf_sticky", 64'(cr_ovf_err), 64'd1);

      // Reset while a command is on the bus
      cmd_in = 64'h8000_0000_0000_0777;
      exp_q.push_back(cmd_in);
      tick();
      cmd_in = '0;
      chk("rs_val_before", 64'(bus_val), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(exp_q.pop_front());
      exp_iss = 0;
      chk("rs_val", 64'(bus_val), 64'd0);
      chk("rs_cmd", bus_cmd, 64'd0);
      chk("rs_credits", 64'(credits), 64'd4);
      chk("rs_issued", 64'(issued_cnt), 64'(exp_iss));
      chk("rs_ovf", 64'(cr_ovf_err), 64'd0);
      chk("rs_busy", 64'(busy), 64'd0);
      chk("rs_rdy", 64'(bus_rdy), 64'd1);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk("idle_ack_ignored_iss", 64'(issued_cnt), 64'(exp_iss));
      chk("idle_ack_ignored_cr", 64'(credits), 64'd4);
      chk("idle_rdy", 64'(bus_rdy), 64'd1);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
